// File: rtl/data_memory.sv
// Byte-addressed data memory for the single-cycle datapath: synchronous write,
// combinational gated read, and an asynchronous active-low clear of the whole array.
module data_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] memAddress,
  input  logic [DATA_WIDTH-1:0] regReadDataTwo,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] memReadData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] memArray [DEPTH];

  // Reset wipes every location at once; a write is honoured only at an edge
  // where RST is already high, so a write pending during reset is dropped.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        memArray[i] <= '0;
      end
    end else if (MemWrite) begin
      memArray[memAddress] <= regReadDataTwo;
    end
  end

  // No write-through: a same-cycle read shows the old contents until the edge.
  assign memReadData = MemRead ? memArray[memAddress] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// traffic compared against an array-based reference of the memory contents.
module tb_data_memory;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          RST;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] regReadDataTwo;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] memReadData;

  logic [DW-1:0] refMem [DEPTH];
  int errors;
  int checks;

  data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .RST(RST),
    .memAddress(memAddress),
    .regReadDataTwo(regReadDataTwo),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected load value from the reference contents.
  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a, input logic rd);
    return rd ? refMem[a] : '0;
  endfunction

  task automatic clearRef();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
  endtask

  // One rising edge; the reference takes the write if reset is released.
  task automatic clockEdge();
    @(posedge clk);
    if (RST === 1'b1 && MemWrite === 1'b1) refMem[memAddress] = regReadDataTwo;
    #1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h06; addrs[2] = 8'hFF;
    @(negedge clk);
    RST = 1'b0;
    clearRef();
    MemRead = 1'b1;
    MemWrite = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      memAddress = addrs[i];
      #1;
      checks++;
      if (memReadData !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold addr=%02h got=%02h exp=00", addrs[i], memReadData);
      end
    end
    @(negedge clk);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      memAddress = addrs[i];
      #1;
      checks++;
      if (memReadData !== 8'h00) begin
        errors++;
        $display("FAIL reset_release addr=%02h got=%02h exp=00", addrs[i], memReadData);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    memAddress = 8'h00;
    regReadDataTwo = 8'hC9;
    MemWrite = 1'b1;
    MemRead = 1'b0;
    clockEdge();
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead = 1'b1;
    memAddress = 8'h00;
    #1;
    checks++;
    if (memReadData !== 8'hC9) begin
      errors++;
      $display("FAIL write_read got=%02h exp=c9", memReadData);
    end
  endtask

  task automatic test_isolation();
    @(negedge clk);
    memAddress = 8'h06;
    regReadDataTwo = 8'h81;
    MemWrite = 1'b1;
    MemRead = 1'b1;
    #1;
    checks++;
    if (memReadData !== 8'h00) begin
      errors++;
      $display("FAIL same_cycle_before_edge got=%02h exp=00", memReadData);
    end
    clockEdge();
    checks++;
    if (memReadData !== 8'h81) begin
      errors++;
      $display("FAIL same_cycle_after_edge got=%02h exp=81", memReadData);
    end
    @(negedge clk);
    MemWrite = 1'b0;
    memAddress = 8'h00;
    #1;
    checks++;
    if (memReadData !== 8'hC9) begin
      errors++;
      $display("FAIL isolation_addr0 got=%02h exp=c9", memReadData);
    end
  endtask

  task automatic test_read_gating();
    @(negedge clk);
    memAddress = 8'h06;
    MemRead = 1'b0;
    #1;
    checks++;
    if (memReadData !== 8'h00) begin
      errors++;
      $display("FAIL read_gated got=%02h exp=00", memReadData);
    end
    MemRead = 1'b1;
    #1;
    checks++;
    if (memReadData !== 8'h81) begin
      errors++;
      $display("FAIL read_ungated got=%02h exp=81", memReadData);
    end
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    MemWrite = 1'b0;
    regReadDataTwo = 8'h55;
    memAddress = 8'h06;
    MemRead = 1'b1;
    clockEdge();
    checks++;
    if (memReadData !== 8'h81) begin
      errors++;
      $display("FAIL write_disabled got=%02h exp=81", memReadData);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    RST = 1'b0;
    clearRef();
    MemRead = 1'b1;
    memAddress = 8'h00;
    #1;
    checks++;
    if (memReadData !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_addr00 got=%02h exp=00", memReadData);
    end
    memAddress = 8'h06;
    #1;
    checks++;
    if (memReadData !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_addr06 got=%02h exp=00", memReadData);
    end
    MemWrite = 1'b1;
    regReadDataTwo = 8'hAA;
    clockEdge();
    checks++;
    if (memReadData !== 8'h00) begin
      errors++;
      $display("FAIL write_during_reset got=%02h exp=00", memReadData);
    end
    @(negedge clk);
    MemWrite = 1'b0;
    RST = 1'b1;
    #1;
    checks++;
    if (memReadData !== 8'h00) begin
      errors++;
      $display("FAIL after_release got=%02h exp=00", memReadData);
    end
    MemWrite = 1'b1;
    regReadDataTwo = 8'h3C;
    clockEdge();
    checks++;
    if (memReadData !== 8'h3C) begin
      errors++;
      $display("FAIL first_write_after_release got=%02h exp=3c", memReadData);
    end
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] expv;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      memAddress = AW'($urandom_range(0, DEPTH - 1));
      regReadDataTwo = DW'($urandom);
      MemRead = 1'($urandom_range(0, 3) != 0);
      MemWrite = 1'($urandom_range(0, 1));
      #1;
      expv = refRead(memAddress, MemRead);
      checks++;
      if (memReadData !== expv) begin
        errors++;
        $display("FAIL rand_pre n=%0d addr=%02h got=%02h exp=%02h", n, memAddress, memReadData, expv);
      end
      clockEdge();
      expv = refRead(memAddress, MemRead);
      checks++;
      if (memReadData !== expv) begin
        errors++;
        $display("FAIL rand_post n=%0d addr=%02h got=%02h exp=%02h", n, memAddress, memReadData, expv);
      end
    end
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic test_sweep();
    @(negedge clk);
    MemRead = 1'b1;
    MemWrite = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      memAddress = AW'(i);
      #1;
      checks++;
      if (memReadData !== refMem[i]) begin
        errors++;
        $display("FAIL sweep addr=%02h got=%02h exp=%02h", i, memReadData, refMem[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    memAddress = '0;
    regReadDataTwo = '0;
    #2;
    RST = 1'b0;
    clearRef();
    #1;
    test_reset();
    test_write_read();
    test_isolation();
    test_read_gating();
    test_write_disabled();
    test_sweep();
    test_async_reset();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
